// File: rtl/vec_mem_seq_if.sv
// Request, result and memory-bus signals of the vector load/store sequencer.
// The sequencer sits on the slave side; the control FSM and memory sit on the master side.
interface vec_mem_seq_if #(
    parameter int ELEM_W = 16,
    parameter int LANES  = 16,
    parameter int ADDR_W = 16
);
    logic                      start;
    logic                      is_store;
    logic [ADDR_W-1:0]         base_addr;
    logic [ADDR_W-1:0]         stride;
    logic [$clog2(LANES):0]    vl;
    logic [LANES*ELEM_W-1:0]   st_data;
    logic [LANES*ELEM_W-1:0]   ld_data;
    logic                      busy;
    logic                      done;
    logic [ADDR_W-1:0]         Addr;
    logic                      RD;
    logic                      WR;
    logic [ELEM_W-1:0]         dataOut;
    logic [ELEM_W-1:0]         DataIn;

    modport slave (
        input  start, is_store, base_addr, stride, vl, st_data, DataIn,
        output ld_data, busy, done, Addr, RD, WR, dataOut
    );

    modport master (
        output start, is_store, base_addr, stride, vl, st_data, DataIn,
        input  ld_data, busy, done, Addr, RD, WR, dataOut
    );
endinterface

// File: rtl/vec_mem_seq.sv
// Vector load/store sequencer: walks N strided addresses on the single-port memory bus,
// gathering read data into ld_data (load) or emitting latched lanes (store).
module vec_mem_seq #(
    parameter int ELEM_W = 16,
    parameter int LANES  = 16,
    parameter int ADDR_W = 16
) (
    input logic          Clk1,
    input logic          Reset,
    vec_mem_seq_if.slave bus
);
    localparam int CW = $clog2(LANES) + 1;
    localparam int KI = $clog2(LANES);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_STORE, S_DONE} state_t;

    state_t                       state_q, state_d;
    logic [CW-1:0]                k_q, k_d;
    logic [CW-1:0]                n_q, n_d;
    logic [ADDR_W-1:0]            addr_q, addr_d;
    logic [ADDR_W-1:0]            stride_q, stride_d;
    logic [LANES-1:0][ELEM_W-1:0] st_q, st_d;
    logic [LANES-1:0][ELEM_W-1:0] ld_q, ld_d;
    logic [CW-1:0]                vl_eff;
    logic                         last;

    assign vl_eff = (bus.vl == '0 || bus.vl > CW'(LANES)) ? CW'(LANES) : bus.vl;
    assign last   = (k_q == n_q - CW'(1));

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        n_d      = n_q;
        addr_d   = addr_q;
        stride_d = stride_q;
        st_d     = st_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    k_d      = '0;
                    n_d      = vl_eff;
                    addr_d   = bus.base_addr;
                    stride_d = bus.stride;
                    st_d     = bus.st_data;
                    state_d  = bus.is_store ? S_STORE : S_LOAD;
                end
            end
            S_LOAD, S_STORE: begin
                // Accumulated address wraps modulo 2^ADDR_W by truncation.
                addr_d = addr_q + stride_q;
                k_d    = k_q + CW'(1);
                if (last) state_d = (state_q == S_LOAD) ? S_DRAIN : S_DONE;
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Read data lags RD by one cycle, so lane k-1 is captured while lane k is issued.
    always_comb begin
        ld_d = ld_q;
        for (int i = 0; i < LANES; i++) begin
            if (state_q == S_LOAD && k_q == CW'(i + 1))
                ld_d[i] = bus.DataIn;
            if (state_q == S_DRAIN) begin
                if (CW'(i) == n_q - CW'(1))
                    ld_d[i] = bus.DataIn;
                else if (CW'(i) >= n_q)
                    ld_d[i] = '0;
            end
        end
    end

    always_ff @(posedge Clk1) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            n_q      <= '0;
            addr_q   <= '0;
            stride_q <= '0;
            st_q     <= '0;
            ld_q     <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            n_q      <= n_d;
            addr_q   <= addr_d;
            stride_q <= stride_d;
            st_q     <= st_d;
            ld_q     <= ld_d;
        end
    end

    assign bus.busy    = (state_q != S_IDLE);
    assign bus.done    = (state_q == S_DONE);
    assign bus.RD      = (state_q == S_LOAD);
    assign bus.WR      = (state_q == S_STORE);
    assign bus.Addr    = (state_q == S_LOAD || state_q == S_STORE) ? addr_q : '0;
    assign bus.dataOut = (state_q == S_STORE) ? st_q[k_q[KI-1:0]] : '0;
    assign bus.ld_data = ld_q;
endmodule

// File: tb/tb_vec_mem_seq.sv
// Directed bench for vec_mem_seq with a zero-wait 64K x 16 memory model.
module tb_vec_mem_seq;
    logic        Clk1;
    logic        Reset;
    logic        pl_en;
    logic [15:0] pl_addr;
    logic [15:0] pl_data;
    bit   [15:0] mem [0:65535];
    int          wr_cnt;
    int          n_assert;
    int          n_fail;

    vec_mem_seq_if #(.ELEM_W(16), .LANES(16), .ADDR_W(16)) bus ();

    vec_mem_seq #(.ELEM_W(16), .LANES(16), .ADDR_W(16)) dut (
        .Clk1  (Clk1),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk1 = 1'b0;
    always #5 Clk1 = ~Clk1;

    always @(posedge Clk1) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (bus.RD) bus.DataIn <= mem[bus.Addr];
        if (bus.WR) begin
            mem[bus.Addr] <= bus.dataOut;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [15:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge Clk1);
        pl_en = 1'b0;
    endtask

    task automatic req(input logic st, input logic [15:0] base, input logic [15:0] strd,
                       input logic [4:0] v, input logic [255:0] data);
        bus.is_store  = st;
        bus.base_addr = base;
        bus.stride    = strd;
        bus.vl        = v;
        bus.st_data   = data;
        bus.start     = 1'b1;
    endtask

    logic [255:0] exp_v;
    logic [255:0] st_vec;
    logic [15:0]  st_addr [4];

    initial begin
        Reset = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        bus.start = 1'b0; bus.is_store = 1'b0; bus.base_addr = '0;
        bus.stride = '0; bus.vl = '0; bus.st_data = '0;
        st_addr[0] = 16'hFFFE; st_addr[1] = 16'h0001; st_addr[2] = 16'h0004; st_addr[3] = 16'h0007;

        // Reset state
        repeat (2) @(negedge Clk1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_rd", bus.RD, 0);
        chk("rst_wr", bus.WR, 0);
        chk("rst_addr", bus.Addr, 0);
        chk("rst_dout", bus.dataOut, 0);
        chk("rst_ld", bus.ld_data, 0);
        Reset = 1'b0;

        for (int i = 0; i < 16; i++) poke(16'h0100 + 16'(i), 16'hA000 + 16'(i));
        poke(16'h0020, 16'hB020); poke(16'h0021, 16'hB021);
        poke(16'h0022, 16'hB022); poke(16'h0023, 16'hB023);
        poke(16'h0024, 16'hB024); poke(16'h0025, 16'hB025);
        poke(16'h0300, 16'h5A5A); poke(16'h0301, 16'h1234);

        // Full unit-stride load, vl=0 -> 16 lanes
        req(1'b0, 16'h0100, 16'h0001, 5'd0, '0);
        @(negedge Clk1); bus.start = 1'b0;
        chk("ld_busy", bus.busy, 1);
        for (int c = 0; c < 16; c++) begin
            chk("ld_rd", bus.RD, 1);
            chk("ld_wr", bus.WR, 0);
            chk("ld_addr", bus.Addr, 16'h0100 + 16'(c));
            chk("ld_done_early", bus.done, 0);
            @(negedge Clk1);
        end
        chk("ld_drain_rd", bus.RD, 0);
        chk("ld_drain_busy", bus.busy, 1);
        chk("ld_drain_done", bus.done, 0);
        @(negedge Clk1);
        for (int i = 0; i < 16; i++) exp_v[i*16 +: 16] = 16'hA000 + 16'(i);
        chk("ld_done", bus.done, 1);
        chk("ld_data", bus.ld_data, exp_v);
        @(negedge Clk1);
        chk("ld_done_pulse", bus.done, 0);
        chk("ld_idle_busy", bus.busy, 0);

        // Strided store with wrap, vl=4; starts during STORE and DONE must be ignored
        for (int i = 0; i < 16; i++) st_vec[i*16 +: 16] = (i < 4) ? 16'h1111 * 16'(i + 1) : 16'hDEAD;
        req(1'b1, 16'hFFFE, 16'h0003, 5'd4, st_vec);
        @(negedge Clk1); bus.start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("st_wr", bus.WR, 1);
            chk("st_rd", bus.RD, 0);
            chk("st_addr", bus.Addr, st_addr[c]);
            chk("st_dout", bus.dataOut, 16'h1111 * 16'(c + 1));
            if (c == 1) begin
                bus.start = 1'b1; bus.is_store = 1'b0; bus.base_addr = 16'h5000;
            end
            if (c == 2) bus.start = 1'b0;
            @(negedge Clk1);
        end
        chk("st_done", bus.done, 1);
        chk("st_done_wr", bus.WR, 0);
        chk("st_done_addr", bus.Addr, 0);
        chk("st_ld_kept", bus.ld_data, exp_v);
        req(1'b0, 16'h0020, 16'h0002, 5'd3, '0);
        @(negedge Clk1);
        chk("ign_busy", bus.busy, 0);
        chk("ign_rd", bus.RD, 0);
        chk("ign_done", bus.done, 0);
        chk("st_mem0", mem[16'hFFFE], 16'h1111);
        chk("st_mem1", mem[16'h0001], 16'h2222);
        chk("st_mem2", mem[16'h0004], 16'h3333);
        chk("st_mem3", mem[16'h0007], 16'h4444);
        chk("st_mem_lane4", mem[16'h000A], 16'h0000);
        chk("st_wr_cnt", wr_cnt, 4);

        // Partial load accepted from the IDLE cycle after DONE
        @(negedge Clk1); bus.start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("pl_rd", bus.RD, 1);
            chk("pl_addr", bus.Addr, 16'h0020 + 16'(2 * c));
            @(negedge Clk1);
        end
        chk("pl_drain_rd", bus.RD, 0);
        chk("pl_drain_done", bus.done, 0);
        @(negedge Clk1);
        exp_v = '0;
        exp_v[15:0] = 16'hB020; exp_v[31:16] = 16'hB022; exp_v[47:32] = 16'hB024;
        chk("pl_done", bus.done, 1);
        chk("pl_data", bus.ld_data, exp_v);
        @(negedge Clk1);

        // Stride zero, vl=17 -> 16 reads of base
        req(1'b0, 16'h0300, 16'h0000, 5'd17, '0);
        @(negedge Clk1); bus.start = 1'b0;
        for (int c = 0; c < 16; c++) begin
            chk("s0_rd", bus.RD, 1);
            chk("s0_addr", bus.Addr, 16'h0300);
            @(negedge Clk1);
        end
        chk("s0_drain_rd", bus.RD, 0);
        @(negedge Clk1);
        for (int i = 0; i < 16; i++) exp_v[i*16 +: 16] = 16'h5A5A;
        chk("s0_done", bus.done, 1);
        chk("s0_data", bus.ld_data, exp_v);
        @(negedge Clk1);

        // Reset in the third LOAD cycle
        req(1'b0, 16'h0100, 16'h0001, 5'd0, '0);
        @(negedge Clk1); bus.start = 1'b0;
        chk("mr_rd1", bus.RD, 1);
        @(negedge Clk1);
        @(negedge Clk1);
        chk("mr_rd3", bus.RD, 1);
        chk("mr_addr3", bus.Addr, 16'h0102);
        Reset = 1'b1;
        @(negedge Clk1);
        Reset = 1'b0;
        chk("mr_busy", bus.busy, 0);
        chk("mr_rd", bus.RD, 0);
        chk("mr_done", bus.done, 0);
        chk("mr_addr", bus.Addr, 0);
        chk("mr_ld", bus.ld_data, 0);
        @(negedge Clk1);
        chk("mr_done_after", bus.done, 0);
        chk("mr_busy_after", bus.busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
